// File: rtl/balance_mlp_top.sv
// Fixed-coefficient printed-MLP classifier for the UCI Balance Scale dataset.
// Two multiplicative hidden neurons (left and right torque), three output
// scores (B, L, R) and an argmax; the class index is registered once.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset; forces out to 0 immediately
//   inp    - packed attributes, a[i] = inp[4*i+3:4*i]
//            a0 = left weight, a1 = left distance,
//            a2 = right weight, a3 = right distance
//   out    - registered class index: 0 = Balanced, 1 = Left, 2 = Right
module balance_mlp_top #(
  parameter int unsigned NUM_A    = 4,
  parameter int unsigned WIDTH_A  = 4,
  parameter int unsigned OUTWIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_A*WIDTH_A-1:0]   inp,
  output logic [OUTWIDTH-1:0]        out
);

  localparam int unsigned PROD_W  = 2 * WIDTH_A;
  localparam int unsigned SCORE_W = PROD_W + 1;

  localparam logic [OUTWIDTH-1:0] CLS_B = OUTWIDTH'(0);
  localparam logic [OUTWIDTH-1:0] CLS_L = OUTWIDTH'(1);
  localparam logic [OUTWIDTH-1:0] CLS_R = OUTWIDTH'(2);

  logic [WIDTH_A-1:0]        lw, ld, rw, rd;
  logic [PROD_W-1:0]         h0, h1;
  logic signed [SCORE_W-1:0] s_l, s_r;
  logic [OUTWIDTH-1:0]       class_c;

  assign lw = inp[0*WIDTH_A +: WIDTH_A];
  assign ld = inp[1*WIDTH_A +: WIDTH_A];
  assign rw = inp[2*WIDTH_A +: WIDTH_A];
  assign rd = inp[3*WIDTH_A +: WIDTH_A];

  // Hidden neurons: torques, full-width products (max 225 fits in 8 bits).
  assign h0 = PROD_W'(lw) * PROD_W'(ld);
  assign h1 = PROD_W'(rw) * PROD_W'(rd);

  // Output scores; the balanced score is the constant 0.
  assign s_l = $signed({1'b0, h0}) - $signed({1'b0, h1});
  assign s_r = $signed({1'b0, h1}) - $signed({1'b0, h0});

  // Argmax with ties resolved to Balanced.
  always_comb begin
    class_c = CLS_B;
    if (s_l > SCORE_W'(0)) begin
      class_c = CLS_L;
    end else if (s_r > SCORE_W'(0)) begin
      class_c = CLS_R;
    end
  end

  // Single output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= CLS_B;
    end else begin
      out <= class_c;
    end
  end

endmodule

// File: tb/tb_balance_mlp_top.sv
// Self-checking bench for balance_mlp_top: a driver pushes the expected class
// of each applied vector into a queue; a monitor pops and compares one entry
// per clock edge. Reset behaviour is checked directly by the driver.
module tb_balance_mlp_top;

  logic        clk;
  logic        rst_n;
  logic [15:0] inp;
  logic [1:0]  out;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  balance_mlp_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inp   (inp),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: compare left torque with right torque.
  function automatic logic [1:0] ref_class(input int lw, input int ld,
                                           input int rw, input int rd);
    int l, r;
    l = lw * ld;
    r = rw * rd;
    if (l > r) return 2'd1;
    if (r > l) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [1:0] act,
                       input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (inp=%h)", name, act, exp, inp);
    end
  endtask

  // Drive one vector at the falling edge and queue its expected class.
  task automatic apply(input int lw, input int ld, input int rw, input int rd);
    @(negedge clk);
    inp = {4'(rd), 4'(rw), 4'(ld), 4'(lw)};
    exp_q.push_back(ref_class(lw, ld, rw, rd));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: output is presented every cycle; compare once per edge.
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("class", out, e);
      end
    end
  end

  initial begin
    int lw, ld, rw, rd;
    rst_n = 1'b1;
    inp   = 16'($urandom);
    #2 rst_n = 1'b0;
    #1 check("reset_async", out, 2'd0);

    @(negedge clk);
    rst_n = 1'b1;
    // Directed cases, including back-to-back and range extremes.
    apply(1, 1, 1, 1);
    apply(5, 5, 1, 1);
    apply(1, 2, 3, 4);
    apply(2, 3, 3, 2);
    apply(0, 7, 0, 9);
    apply(15, 15, 15, 14);
    apply(15, 14, 15, 15);
    apply(15, 15, 15, 15);
    apply(0, 15, 1, 1);
    apply(15, 15, 15, 15);
    drain();

    // Exhaustive dataset range.
    for (int a = 1; a <= 5; a++)
      for (int b = 1; b <= 5; b++)
        for (int c = 1; c <= 5; c++)
          for (int d = 1; d <= 5; d++)
            apply(a, b, c, d);
    drain();

    // Random full-range codes, with occasional repeats to check hold.
    for (int i = 0; i < 300; i++) begin
      lw = $urandom_range(0, 15);
      ld = $urandom_range(0, 15);
      rw = $urandom_range(0, 15);
      rd = $urandom_range(0, 15);
      apply(lw, ld, rw, rd);
      if ($urandom_range(0, 3) == 0) apply(lw, ld, rw, rd);
    end
    drain();

    // Reset mid-stream while out = 2, then recovery on the current inp.
    apply(1, 2, 3, 4);
    drain();
    check("pre_reset_R", out, 2'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_async", out, 2'd0);
    @(negedge clk);
    check("reset_held", out, 2'd0);
    rst_n = 1'b1;
    exp_q.push_back(ref_class(1, 2, 3, 4));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
